call_seq: RTL and testbench
===========================

# call_seq

Program-counter sequencer with call/return control for the accumulator processor; drives the return-address stack directly. Each accepted step either advances, jumps, calls (pushing the return address onto the stack) or returns (popping it). The block tracks stack occupancy itself, so overflow and underflow are caught before the stack is ever driven past its limits.

## Interface
- `width`, 8: PC/address width in bits; must equal the stack's `width`.
- `depth`, 3: stack capacity is 2**`depth` entries; must equal the stack's `depth`.
- `clk` in 1: clock, rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `step` in 1: advance request; sampled only in RUN.
- `op` in 2: 00 next, 01 jump, 10 call, 11 return; qualified by `step`.
- `target` in `width`: jump/call destination.
- `stk_q` in `width`: stack `data_out`.
- `stk_en` out 1: stack `en`; combinational.
- `stk_con` out 2: stack `con`; combinational, 10 when idle.
- `stk_d` out `width`: stack `data_in` = `pc`+1; combinational.
- `pc` out `width`: current program counter.
- `busy` out 1: high in RET_LOAD; `step` is ignored.
- `level` out `depth`+1: number of entries held on the stack.
- `ovf` out 1: sticky; a call was attempted with a full stack.
- `unf` out 1: sticky; a return was attempted with an empty stack.

## Operation
- Reset (`clr`=0, asynchronous) forces:
  - state = RUN;
  - `pc`=0, `level`=0, `ovf`=0, `unf`=0, `busy`=0;
  - `stk_en`=0, `stk_con`=10.
- Two states: RUN and RET_LOAD.
- RUN, `step`=0: hold all registers; `stk_en`=0.
- RUN, `step`=1:
  - op 00: `pc`<=`pc`+1.
  - op 01: `pc`<=`target`.
  - op 10, `level`<2**`depth`:
    - same cycle: `stk_en`=1, `stk_con`=00, `stk_d`=`pc`+1;
    - at the edge: `pc`<=`target`, `level`<=`level`+1.
  - op 10, `level`=2**`depth`: no stack access; `pc`<=`pc`+1; `ovf`<=1.
  - op 11, `level`>0:
    - same cycle: `stk_en`=1, `stk_con`=01;
    - at the edge: `level`<=`level`-1, go to RET_LOAD.
  - op 11, `level`=0: no stack access; `pc`<=`pc`+1; `unf`<=1.
- RET_LOAD:
  - `stk_en`=0, `busy`=1;
  - at the edge: `pc`<=`stk_q`, go to RUN.
- Arithmetic:
  - `pc`+1 is modulo 2**`width`; `pc`=all-ones wraps to 0, and a call from that `pc` pushes 0.
  - `level` never exceeds 2**`depth` and never underflows.
- `ovf` and `unf` clear only on reset.

## Timing
- next, jump and call take 1 cycle: the new `pc` is visible the cycle after the accepted `step`.
- Return takes 2 cycles:
  - cycle N: pop is issued;
  - edge N: the stack updates `data_out`;
  - cycle N+1: RET_LOAD;
  - edge N+1: `pc`=`stk_q`, valid from cycle N+2.
- `stk_*` outputs are combinational from state, `step`, `op` and `level`, so the stack samples them on the same edge that updates `pc`.
- A `step` presented while `busy`=1 is dropped; the requester must hold it until `busy`=0.
- Back-to-back call then return is legal: the push lands at edge N, the pop is issued at N+1, and the pushed value returns at N+3.
- Reset mid-return (in RET_LOAD) aborts the load: `pc`=0 immediately.
- The stack's synchronous clear must be tied to the same `clr`, so that `level`=0 matches an empty stack.

## Test plan
- Reset, then 3 steps with op 00 → `pc` reads 0,1,2,3; `stk_en` stays 0 throughout.
- From `pc`=5: call with `target`=0x40 → `stk_d`=6 with `stk_con`=00 in that cycle; then `pc`=0x40, `level`=1. Return → `busy` high for 1 cycle, then `pc`=6, `level`=0.
- Nested calls from `pc` 0x10, 0x20, 0x30, then 3 returns → `pc` reads 0x31, then 0x21, then 0x11.
- 8 calls (`depth`=3), then a 9th call from `pc`=0x50 → `ovf`=1, no push, `pc`=0x51, `level`=8. Then 8 returns succeed and a 9th return gives `unf`=1 with `pc`+1.
- From `pc`=0xFF: call with `target`=0x10 → pushes 0x00; return → `pc`=0x00.
- Assert `clr` during RET_LOAD → `pc`, `level`, `busy`, `ovf`, `unf` all 0 without waiting for a clock edge. Also: toggling `step` while `busy`=1 has no effect.

Source files
------------

// File: rtl/call_seq_if.sv
// Bundle between the call/return sequencer, its requester and the return-address stack.
interface call_seq_if #(
  parameter int width = 8,
  parameter int depth = 3
);
  logic             step;
  logic [1:0]       op;
  logic [width-1:0] target;
  logic [width-1:0] stk_q;
  logic             stk_en;
  logic [1:0]       stk_con;
  logic [width-1:0] stk_d;
  logic [width-1:0] pc;
  logic             busy;
  logic [depth:0]   level;
  logic             ovf;
  logic             unf;

  modport master (
    output step, op, target, stk_q,
    input  stk_en, stk_con, stk_d, pc, busy, level, ovf, unf
  );

  modport slave (
    input  step, op, target, stk_q,
    output stk_en, stk_con, stk_d, pc, busy, level, ovf, unf
  );
endinterface

// File: rtl/call_seq.sv
// Program-counter sequencer with next/jump/call/return; drives the return-address stack
// and tracks its occupancy so overflow/underflow never reach the stack.
//
// state    | meaning
// RUN      | accepting steps; call pushes, return pops
// RET_LOAD | popped return address is on stk_q; load it into pc
module call_seq #(
  parameter int width = 8,
  parameter int depth = 3
) (
  input logic       clk,
  input logic       clr,
  call_seq_if.slave bus
);
  typedef enum logic {RUN, RET_LOAD} state_t;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] CON_PUSH = 2'b00;
  localparam logic [1:0] CON_POP  = 2'b01;
  localparam logic [1:0] CON_IDLE = 2'b10;
  localparam logic [depth:0] LEVEL_FULL = {1'b1, {depth{1'b0}}};

  state_t           state, state_n;
  logic [width-1:0] pc, pc_n, pc_inc;
  logic [depth:0]   level, level_n;
  logic             ovf, ovf_n, unf, unf_n;
  logic             stk_en;
  logic [1:0]       stk_con;

  assign pc_inc = pc + 1'b1;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= RUN;
      pc    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      level <= level_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    level_n = level;
    ovf_n   = ovf;
    unf_n   = unf;
    stk_en  = 1'b0;
    stk_con = CON_IDLE;
    case (state)
      RUN: begin
        if (bus.step) begin
          case (bus.op)
            OP_NEXT: pc_n = pc_inc;
            OP_JUMP: pc_n = bus.target;
            OP_CALL: begin
              if (level != LEVEL_FULL) begin
                stk_en  = 1'b1;
                stk_con = CON_PUSH;
                pc_n    = bus.target;
                level_n = level + 1'b1;
              end else begin
                pc_n  = pc_inc;
                ovf_n = 1'b1;
              end
            end
            default: begin
              // pop is issued now; the stack presents the address on the next cycle
              if (level != '0) begin
                stk_en  = 1'b1;
                stk_con = CON_POP;
                level_n = level - 1'b1;
                state_n = RET_LOAD;
              end else begin
                pc_n  = pc_inc;
                unf_n = 1'b1;
              end
            end
          endcase
        end
      end
      RET_LOAD: begin
        pc_n    = bus.stk_q;
        state_n = RUN;
      end
      default: state_n = RUN;
    endcase
  end

  assign bus.stk_en  = stk_en;
  assign bus.stk_con = stk_con;
  assign bus.stk_d   = pc_inc;
  assign bus.pc      = pc;
  assign bus.busy    = (state == RET_LOAD);
  assign bus.level   = level;
  assign bus.ovf     = ovf;
  assign bus.unf     = unf;
endmodule

// File: tb/tb_call_seq.sv
// Directed bench for call_seq with a behavioural return-address stack.
module tb_call_seq;
  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   errors = 0;

  call_seq_if #(.width(W), .depth(D)) bus ();

  call_seq #(.width(W), .depth(D)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // return-address stack model, cleared by the same clr
  logic [W-1:0] mem [0:(1<<D)-1];
  int           sp;
  logic [W-1:0] q;
  assign bus.stk_q = q;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      sp <= 0;
      q  <= '0;
    end else if (bus.stk_en) begin
      if (bus.stk_con == 2'b00 && sp < (1<<D)) begin
        mem[sp] <= bus.stk_d;
        sp      <= sp + 1;
      end else if (bus.stk_con == 2'b01 && sp > 0) begin
        q  <= mem[sp-1];
        sp <= sp - 1;
      end
    end
  end

  typedef struct {
    logic         step;
    logic [1:0]   op;
    logic [W-1:0] target;
    logic         exp_en;
    logic [1:0]   exp_con;
    logic [W-1:0] exp_pc;
    logic [D:0]   exp_level;
    logic         exp_busy;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // drive from posedge+1, sample stack controls at negedge, return at next posedge+1
  task automatic cycle(input logic st, input logic [1:0] o, input logic [W-1:0] tgt,
                       output logic en, output logic [1:0] con, output logic [W-1:0] d);
    bus.step   = st;
    bus.op     = o;
    bus.target = tgt;
    @(negedge clk);
    en  = bus.stk_en;
    con = bus.stk_con;
    d   = bus.stk_d;
    @(posedge clk);
    #1;
    bus.step = 1'b0;
  endtask

  function automatic vec_t mk(logic st, logic [1:0] o, logic [W-1:0] tgt, logic en,
                              logic [1:0] con, logic [W-1:0] p, logic [D:0] lv, logic b);
    vec_t v;
    v.step = st; v.op = o; v.target = tgt; v.exp_en = en; v.exp_con = con;
    v.exp_pc = p; v.exp_level = lv; v.exp_busy = b;
    return v;
  endfunction

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic         en;
    logic [1:0]   con;
    logic [W-1:0] d;
    logic [W-1:0] prev_pc;
    logic [W-1:0] exp_ret;

    bus.step = 1'b0; bus.op = 2'b00; bus.target = '0;

    vecs.push_back(mk(1, 2'b00, 8'h00, 0, 2'b10, 8'h01, 0, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 0, 2'b10, 8'h02, 0, 0));
    vecs.push_back(mk(1, 2'b00, 8'h00, 0, 2'b10, 8'h03, 0, 0));
    vecs.push_back(mk(0, 2'b10, 8'h77, 0, 2'b10, 8'h03, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'h05, 0, 2'b10, 8'h05, 0, 0));
    vecs.push_back(mk(1, 2'b10, 8'h40, 1, 2'b00, 8'h40, 1, 0));
    vecs.push_back(mk(1, 2'b11, 8'h00, 1, 2'b01, 8'h40, 0, 1));
    vecs.push_back(mk(1, 2'b00, 8'h00, 0, 2'b10, 8'h06, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'hFF, 0, 2'b10, 8'hFF, 0, 0));
    vecs.push_back(mk(1, 2'b10, 8'h10, 1, 2'b00, 8'h10, 1, 0));
    vecs.push_back(mk(1, 2'b11, 8'h00, 1, 2'b01, 8'h10, 0, 1));
    vecs.push_back(mk(1, 2'b01, 8'h99, 0, 2'b10, 8'h00, 0, 0));
    vecs.push_back(mk(1, 2'b01, 8'h10, 0, 2'b10, 8'h10, 0, 0));
    vecs.push_back(mk(1, 2'b10, 8'h20, 1, 2'b00, 8'h20, 1, 0));
    vecs.push_back(mk(1, 2'b10, 8'h30, 1, 2'b00, 8'h30, 2, 0));
    vecs.push_back(mk(1, 2'b10, 8'h60, 1, 2'b00, 8'h60, 3, 0));
    vecs.push_back(mk(1, 2'b11, 8'h00, 1, 2'b01, 8'h60, 2, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 0, 2'b10, 8'h31, 2, 0));
    vecs.push_back(mk(1, 2'b11, 8'h00, 1, 2'b01, 8'h31, 1, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 0, 2'b10, 8'h21, 1, 0));
    vecs.push_back(mk(1, 2'b11, 8'h00, 1, 2'b01, 8'h21, 0, 1));
    vecs.push_back(mk(0, 2'b00, 8'h00, 0, 2'b10, 8'h11, 0, 0));

    #12;
    chk("reset_pc", int'(bus.pc), 0);
    chk("reset_level", int'(bus.level), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_flags", int'({bus.ovf, bus.unf}), 0);
    chk("reset_stk_en", int'(bus.stk_en), 0);
    chk("reset_stk_con", int'(bus.stk_con), 2);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;

    prev_pc = 8'h00;
    foreach (vecs[i]) begin
      cycle(vecs[i].step, vecs[i].op, vecs[i].target, en, con, d);
      chk($sformatf("v%0d_stk_en", i), int'(en), int'(vecs[i].exp_en));
      chk($sformatf("v%0d_stk_con", i), int'(con), int'(vecs[i].exp_con));
      chk($sformatf("v%0d_stk_d", i), int'(d), int'(W'(prev_pc + 1'b1)));
      chk($sformatf("v%0d_pc", i), int'(bus.pc), int'(vecs[i].exp_pc));
      chk($sformatf("v%0d_level", i), int'(bus.level), int'(vecs[i].exp_level));
      chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(vecs[i].exp_busy));
      prev_pc = vecs[i].exp_pc;
    end

    // fill the stack, then overflow from pc 0x50
    cycle(1, 2'b01, 8'h00, en, con, d);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 2'b10, 8'h50, en, con, d);
      chk($sformatf("fill%0d_push", i), int'({en, con}), 4);
    end
    chk("full_level", int'(bus.level), 8);
    cycle(1, 2'b10, 8'h22, en, con, d);
    chk("ovf_no_push", int'(en), 0);
    chk("ovf_pc", int'(bus.pc), 8'h51);
    chk("ovf_level", int'(bus.level), 8);
    chk("ovf_flag", int'(bus.ovf), 1);

    for (int i = 0; i < 8; i++) begin
      exp_ret = (i == 7) ? 8'h01 : 8'h51;
      cycle(1, 2'b11, 8'h00, en, con, d);
      chk($sformatf("drain%0d_pop", i), int'({en, con}), 5);
      cycle(0, 2'b00, 8'h00, en, con, d);
      chk($sformatf("drain%0d_pc", i), int'(bus.pc), int'(exp_ret));
      chk($sformatf("drain%0d_level", i), int'(bus.level), 7 - i);
    end
    cycle(1, 2'b11, 8'h00, en, con, d);
    chk("unf_no_pop", int'(en), 0);
    chk("unf_pc", int'(bus.pc), 8'h02);
    chk("unf_level", int'(bus.level), 0);
    chk("unf_flag", int'(bus.unf), 1);
    chk("ovf_sticky", int'(bus.ovf), 1);

    // asynchronous reset while in RET_LOAD
    cycle(1, 2'b10, 8'h80, en, con, d);
    cycle(1, 2'b11, 8'h00, en, con, d);
    chk("pre_clr_busy", int'(bus.busy), 1);
    #1;
    clr = 1'b0;
    #1;
    chk("clr_pc", int'(bus.pc), 0);
    chk("clr_level", int'(bus.level), 0);
    chk("clr_busy", int'(bus.busy), 0);
    chk("clr_ovf", int'(bus.ovf), 0);
    chk("clr_unf", int'(bus.unf), 0);
    chk("clr_stk", int'({bus.stk_en, bus.stk_con}), 2);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 2'b00, 8'h00, en, con, d);
    chk("post_clr_pc", int'(bus.pc), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
